// File: rtl/mem_ctrl.sv
// Arbiter/sequencer for the shared 8-bit RAM port. It serialises IF fetches and MEM loads/stores into byte
// transfers, assembles little-endian results and returns a one-cycle done pulse.
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  branch_flag_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  input  logic                  mem_req_in,
  input  logic                  mem_we_in,
  input  logic [1:0]            mem_len_in,
  input  logic [31:0]           mem_addr_in,
  input  logic [31:0]           mem_wdata_in,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic [RAM_ADDR_W-1:0] ram_a_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_din
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d, len_q, len_d;
  logic [RAM_ADDR_W-1:0] base_q, base_d, ram_a_q, ram_a_d;
  logic [31:0]           wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0]           if_inst_q, if_inst_d, mem_rdata_q, mem_rdata_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;

  logic [2:0] cnt_nx;
  logic [1:0] byte_idx;
  logic       unused_addr_hi;

  assign cnt_nx         = cnt_q + 3'd1;
  // Byte landing on this edge was addressed two edges ago.
  assign byte_idx       = cnt_q[1:0] - 2'd1;
  assign unused_addr_hi = ^{if_addr_in[31:RAM_ADDR_W], mem_addr_in[31:RAM_ADDR_W]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_in) begin
          base_d  = mem_addr_in[RAM_ADDR_W-1:0];
          ram_a_d = mem_addr_in[RAM_ADDR_W-1:0];
          wdata_d = mem_wdata_in;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
          case (mem_len_in)
            2'd0:    len_d = 3'd1;
            2'd1:    len_d = 3'd2;
            default: len_d = 3'd4;
          endcase
          if (mem_we_in) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_in[7:0];
          end else begin
            state_d = MEM_RD;
          end
        end else if (if_req_in && !branch_flag_in) begin
          state_d = IF_RD;
          base_d  = if_addr_in[RAM_ADDR_W-1:0];
          ram_a_d = if_addr_in[RAM_ADDR_W-1:0];
          len_d   = 3'd4;
          cnt_d   = 3'd0;
          buf_d   = 32'd0;
        end
      end
      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && branch_flag_in) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_nx;
          if (cnt_nx < len_q) ram_a_d = base_q + RAM_ADDR_W'(cnt_nx);
          for (int k = 0; k < 4; k++)
            if (cnt_nx >= 3'd2 && byte_idx == 2'(k)) buf_d[8*k +: 8] = ram_din;
          if (cnt_q == len_q) begin
            state_d = DONE;
            cnt_d   = 3'd0;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = buf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = buf_d;
            end
          end
        end
      end
      MEM_WR: begin
        if (cnt_nx < len_q) begin
          cnt_d   = cnt_nx;
          ram_a_d = base_q + RAM_ADDR_W'(cnt_nx);
          for (int k = 0; k < 4; k++)
            if (cnt_nx[1:0] == 2'(k)) ram_dout_d = wdata_q[8*k +: 8];
        end else begin
          state_d    = DONE;
          cnt_d      = 3'd0;
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
        end
      end
      // One dead cycle so a request still held after its done pulse is not taken again.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign if_inst_o   = if_inst_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_a_o     = ram_a_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_wr_o    = ram_wr_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbiter and sequencer for the single 8-bit, byte-addressed RAM port shared by the IF stage (instruction fetch) and the MEM stage (loads/stores) of the 5-stage RISC-V core. It serialises each 1/2/4-byte access into byte transfers, assembles little-endian results and returns a one-cycle done pulse. The pipeline controller uses the requests and done pulses to drive stall[5:0]. MEM has priority over IF. An in-flight fetch is aborted on a branch.

Parameters:
RAM_ADDR_W, 17, width of the RAM byte address; upper request-address bits are dropped.

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; 0 freezes every register
branch_flag_in  in  1  branch/jump taken; aborts an in-flight fetch
if_req_in  in  1  fetch request, level, held until if_done_o
if_addr_in  in  32  fetch byte address
if_done_o  out  1  one-cycle fetch-complete pulse
if_inst_o  out  32  fetched instruction, valid while if_done_o=1
mem_req_in  in  1  load/store request, level, held until mem_done_o
mem_we_in  in  1  1=store, 0=load
mem_len_in  in  2  0=byte, 1=half, 2=word; 3 is treated as word
mem_addr_in  in  32  data byte address
mem_wdata_in  in  32  store data; low bytes used
mem_done_o  out  1  one-cycle load/store-complete pulse
mem_rdata_o  out  32  load data, zero-extended, valid while mem_done_o=1
ram_a_o  out  RAM_ADDR_W  RAM byte address
ram_dout_o  out  8  RAM write byte
ram_wr_o  out  1  1=write this cycle
ram_din  in  8  RAM read byte; valid one cycle after its address is presented

Behaviour:
- Reset (async, rst_in=1): state=IDLE, byte counter=0. All outputs=0, including both done pulses, data outputs and all ram_* outputs.
- rdy_in=0: all state and outputs hold; no edge counts toward latency.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE. All outputs are registered.
- Acceptance happens only in IDLE.
  - mem_req_in=1: go to MEM_RD or MEM_WR.
  - Otherwise, if_req_in=1 and branch_flag_in=0: go to IF_RD.
  - MEM always wins a tie.
  - On acceptance, latch the address, length N (1/2/4; IF is always 4) and write data. Counter=0.
- Read, N bytes, accept at edge E0:
  - ram_a_o = base+0 at E0, then base+1..base+N-1 at E1..E(N-1).
  - ram_din is captured into byte k at edge E(k+2).
  - Done pulse and data are driven at edge E(N+1), and the state moves to DONE. Word latency = 5 edges.
- Write, N bytes:
  - At E0..E(N-1): ram_wr_o=1, ram_a_o=base+k, ram_dout_o=wdata[8k+7:8k].
  - At E(N): ram_wr_o=0, mem_done_o=1, state moves to DONE.
- DONE: lasts exactly one cycle. Done pulses clear and requests are ignored, so a held request is never re-accepted. The state then returns to IDLE.
- ram_wr_o is 1 only in MEM_WR. ram_a_o holds its last value when idle.
- Address arithmetic is modulo 2^RAM_ADDR_W; a wrap across the top of RAM is allowed. No alignment check.
- Branch abort: branch_flag_in=1 sampled in IF_RD → IDLE at that edge. No if_done_o. Partial data is discarded. A new fetch can be accepted from the next edge.
- branch_flag_in has no effect on MEM_RD or MEM_WR. A MEM access always completes.
- A new mem_req_in during IF_RD waits until the fetch completes or aborts (no preemption).
- Reset mid-access: abandons the access immediately with no done pulse. A write may have been partially performed.

Test Plan:
- Fetch: mem word at 0x100 = bytes 13,05,00,00; IF req addr 0x100 → if_done_o=1 five edges after acceptance for exactly 1 cycle, if_inst_o=0x00000513; ram_wr_o stays 0.
- Store word 0xDEADBEEF to 0x20 then load byte 0x22 and half 0x22 → ram writes EF,BE,AD,DE at 0x20..0x23 over 4 cycles, mem_done_o at E4; load byte returns 0x000000AD at E2; load half returns 0x0000DEAD at E3.
- Simultaneous if_req and mem_req in IDLE → MEM load is served first; fetch is accepted exactly 2 edges after mem_done_o (DONE + IDLE), and neither request is served twice.
- branch_flag_in=1 at E2 of a fetch → no if_done_o; fetch of the new address accepted at E3 with correct data at E3+5.
- rdy_in=0 for 3 cycles mid-read → completion is delayed by exactly 3 cycles and data is unchanged; assert rst_in mid-write → all outputs 0 immediately, state IDLE.
- Wrap: word load at 0x1FFFF (RAM_ADDR_W=17) → ram_a_o sequence 1FFFF,00000,00001,00002; assembled little-endian.
